// File: rtl/tour_move_sequencer_if.sv
// Command-port bundle between the UART path, the tour sequencer and cmd_proc.
// The master modport is the sequencer's view; slave is everyone around it.
interface tour_move_sequencer_if;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  modport master (
    input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );

  modport slave (
    output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  clr_cmd_rdy_UART, cmd, cmd_rdy, resp
  );
endinterface

// File: rtl/tour_move_sequencer.sv
// Turns a solved Knight's tour into vertical/horizontal cmd_proc commands and
// arbitrates the cmd_proc port between the UART path and the tour.
//
// state  | meaning
// IDLE   | UART pass-through, waiting for start_tour
// VERT   | presenting the vertical leg of move mv_indx
// WAIT_V | vertical leg consumed, waiting for send_resp
// HORZ   | presenting the horizontal leg of move mv_indx
// WAIT_H | horizontal leg consumed, waiting for send_resp
module tour_move_sequencer #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_tour,
  input  logic [7:0]           move,
  output logic [IDX_W-1:0]     mv_indx,
  output logic                 tour_busy,
  output logic                 tour_err,
  tour_move_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_MOVES - 1);
  localparam logic [3:0]       OP_MOVE    = 4'h2;
  localparam logic [3:0]       OP_FANFARE = 4'h3;
  localparam logic [7:0]       HDG_N      = 8'h00;
  localparam logic [7:0]       HDG_W      = 8'h3F;
  localparam logic [7:0]       HDG_S      = 8'h7F;
  localparam logic [7:0]       HDG_E      = 8'hBF;
  localparam logic [7:0]       RESP_DONE  = 8'h5A;
  localparam logic [7:0]       RESP_BUSY  = 8'hA5;

  state_t      state;
  logic        vert_entry;
  logic [7:0]  move_reg;
  logic [7:0]  move_cur;
  logic        move_ok;
  logic        last_move;
  logic [15:0] vert_cmd;
  logic [15:0] horz_cmd;

  // mv_indx changes on the edge into VERT, so TourLogic's move for the new
  // index is only valid during the first VERT cycle; use it live there.
  assign move_cur  = vert_entry ? move : move_reg;
  assign move_ok   = $onehot(move_cur);
  assign last_move = (mv_indx == LAST_IDX);
  assign tour_busy = (state != IDLE);

  always_comb begin
    vert_cmd = {OP_MOVE, HDG_N, 4'd0};
    horz_cmd = {OP_FANFARE, HDG_E, 4'd0};
    case (move_cur)
      8'h01: begin
        vert_cmd = {OP_MOVE, HDG_N, 4'd2};
        horz_cmd = {OP_FANFARE, HDG_E, 4'd1};
      end
      8'h02: begin
        vert_cmd = {OP_MOVE, HDG_N, 4'd2};
        horz_cmd = {OP_FANFARE, HDG_W, 4'd1};
      end
      8'h04: begin
        vert_cmd = {OP_MOVE, HDG_N, 4'd1};
        horz_cmd = {OP_FANFARE, HDG_W, 4'd2};
      end
      8'h08: begin
        vert_cmd = {OP_MOVE, HDG_S, 4'd1};
        horz_cmd = {OP_FANFARE, HDG_W, 4'd2};
      end
      8'h10: begin
        vert_cmd = {OP_MOVE, HDG_S, 4'd2};
        horz_cmd = {OP_FANFARE, HDG_W, 4'd1};
      end
      8'h20: begin
        vert_cmd = {OP_MOVE, HDG_S, 4'd2};
        horz_cmd = {OP_FANFARE, HDG_E, 4'd1};
      end
      8'h40: begin
        vert_cmd = {OP_MOVE, HDG_S, 4'd1};
        horz_cmd = {OP_FANFARE, HDG_E, 4'd2};
      end
      8'h80: begin
        vert_cmd = {OP_MOVE, HDG_N, 4'd1};
        horz_cmd = {OP_FANFARE, HDG_E, 4'd2};
      end
      default: ;
    endcase
  end

  // Port mux: pass-through in IDLE, tour legs otherwise.
  always_comb begin
    bus.cmd              = bus.cmd_UART;
    bus.cmd_rdy          = bus.cmd_rdy_UART;
    bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
    bus.resp             = RESP_DONE;
    if (state != IDLE) begin
      bus.clr_cmd_rdy_UART = 1'b0;
      bus.resp             = (state == WAIT_H && last_move) ? RESP_DONE : RESP_BUSY;
      bus.cmd_rdy          = 1'b0;
      bus.cmd              = vert_cmd;
      case (state)
        VERT: begin
          bus.cmd     = vert_cmd;
          bus.cmd_rdy = move_ok;
        end
        HORZ: begin
          bus.cmd     = horz_cmd;
          bus.cmd_rdy = 1'b1;
        end
        WAIT_H:  bus.cmd = horz_cmd;
        default: bus.cmd = vert_cmd;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mv_indx    <= '0;
      tour_err   <= 1'b0;
      vert_entry <= 1'b0;
      move_reg   <= '0;
    end else begin
      tour_err   <= 1'b0;
      vert_entry <= 1'b0;
      case (state)
        IDLE: begin
          if (start_tour) begin
            state      <= VERT;
            mv_indx    <= '0;
            vert_entry <= 1'b1;
          end
        end
        VERT: begin
          if (vert_entry) move_reg <= move;
          if (!move_ok) begin
            tour_err <= 1'b1;
            state    <= IDLE;
            mv_indx  <= '0;
          end else if (bus.clr_cmd_rdy) begin
            state <= bus.send_resp ? HORZ : WAIT_V;
          end
        end
        WAIT_V: begin
          if (bus.send_resp) state <= HORZ;
        end
        HORZ: begin
          if (bus.clr_cmd_rdy && bus.send_resp) begin
            if (last_move) begin
              state <= IDLE;
            end else begin
              state      <= VERT;
              mv_indx    <= mv_indx + IDX_W'(1);
              vert_entry <= 1'b1;
            end
          end else if (bus.clr_cmd_rdy) begin
            state <= WAIT_H;
          end
        end
        WAIT_H: begin
          if (bus.send_resp) begin
            if (last_move) begin
              state <= IDLE;
            end else begin
              state      <= VERT;
              mv_indx    <= mv_indx + IDX_W'(1);
              vert_entry <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tour_move_sequencer.sv
// Scenario bench for tour_move_sequencer: a small cmd_proc/TourLogic stand-in
// drives the handshakes and legs are predicted from knight (dx,dy) arithmetic.
module tb_tour_move_sequencer;
  localparam int NUM_MOVES = 24;
  localparam int IDX_W     = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_tour;
  logic [7:0]       move;
  logic [IDX_W-1:0] mv_indx;
  logic             tour_busy;
  logic             tour_err;

  tour_move_sequencer_if bus ();

  tour_move_sequencer #(.NUM_MOVES(NUM_MOVES), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_tour (start_tour),
    .move       (move),
    .mv_indx    (mv_indx),
    .tour_busy  (tour_busy),
    .tour_err   (tour_err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cmds   = 0;
  bit cnt_en   = 1'b0;

  int DX[8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int DY[8] = '{2, 2, 1, -1, -2, -2, -1, 1};

  always @(negedge clk) if (cnt_en && bus.cmd_rdy && bus.clr_cmd_rdy) n_cmds++;

  function automatic logic [15:0] leg_cmd(input logic [7:0] m, input bit horiz);
    int b = 0;
    int d;
    int a;
    for (int k = 0; k < 8; k++) if (m[k]) b = k;
    d = horiz ? DX[b] : DY[b];
    a = (d < 0) ? -d : d;
    if (!horiz) return {4'h2, ((d > 0) ? 8'h00 : 8'h7F), 4'(a)};
    return {4'h3, ((d > 0) ? 8'hBF : 8'h3F), 4'(a)};
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start_tour = 1'b0;
    move = 8'h00;
    bus.cmd_UART = 16'h0000;
    bus.cmd_rdy_UART = 1'b0;
    bus.clr_cmd_rdy = 1'b0;
    bus.send_resp = 1'b0;
    next();
    next();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next();
    settle();
    n_checks++; if (tour_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", tour_busy); end
    n_checks++; if (mv_indx !== '0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", mv_indx); end
    n_checks++; if (tour_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", tour_err); end
    n_checks++; if (bus.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", bus.cmd_rdy); end
    n_checks++; if (bus.resp !== 8'h5A) begin n_fail++; $display("FAIL reset_resp: got %h want 5a", bus.resp); end
    next();
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [15:0] c;
    logic r, cl;
    bus.cmd_UART = 16'h6020; bus.cmd_rdy_UART = 1'b1; bus.clr_cmd_rdy = 1'b1;
    settle();
    n_checks++; if (bus.cmd !== 16'h6020) begin n_fail++; $display("FAIL pass_cmd: got %h want 6020", bus.cmd); end
    n_checks++; if (bus.clr_cmd_rdy_UART !== 1'b1) begin n_fail++; $display("FAIL pass_clr: got %b want 1", bus.clr_cmd_rdy_UART); end
    n_checks++; if (bus.resp !== 8'h5A) begin n_fail++; $display("FAIL pass_resp: got %h want 5a", bus.resp); end
    n_checks++; if (tour_busy !== 1'b0) begin n_fail++; $display("FAIL pass_busy: got %b want 0", tour_busy); end
    for (int k = 0; k < 6; k++) begin
      next();
      c = 16'($urandom); r = 1'($urandom); cl = 1'($urandom);
      bus.cmd_UART = c; bus.cmd_rdy_UART = r; bus.clr_cmd_rdy = cl;
      settle();
      n_checks++; if (bus.cmd !== c) begin n_fail++; $display("FAIL pass_rand_cmd: got %h want %h", bus.cmd, c); end
      n_checks++; if (bus.cmd_rdy !== r) begin n_fail++; $display("FAIL pass_rand_rdy: got %b want %b", bus.cmd_rdy, r); end
      n_checks++; if (bus.clr_cmd_rdy_UART !== cl) begin n_fail++; $display("FAIL pass_rand_clr: got %b want %b", bus.clr_cmd_rdy_UART, cl); end
    end
    next();
    bus.cmd_rdy_UART = 1'b0; bus.clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_single_move();
    move = 8'h01; start_tour = 1'b1;
    settle();
    n_checks++; if (bus.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL start_early_rdy: got %b want 0", bus.cmd_rdy); end
    next();
    start_tour = 1'b0;
    settle();
    n_checks++; if (tour_busy !== 1'b1) begin n_fail++; $display("FAIL vert_busy: got %b want 1", tour_busy); end
    n_checks++; if (bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL vert_rdy: got %b want 1", bus.cmd_rdy); end
    n_checks++; if (bus.cmd !== 16'h2002) begin n_fail++; $display("FAIL vert_cmd: got %h want 2002", bus.cmd); end
    n_checks++; if (bus.resp !== 8'hA5) begin n_fail++; $display("FAIL vert_resp: got %h want a5", bus.resp); end
    // move changes after entry and a lone send_resp must both be ignored
    next();
    move = 8'hFF; bus.send_resp = 1'b1;
    settle();
    n_checks++; if (bus.cmd !== 16'h2002 || bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL vert_hold: got %h/%b want 2002/1", bus.cmd, bus.cmd_rdy); end
    next();
    bus.send_resp = 1'b0;
    settle();
    n_checks++; if (bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL vert_send_ignored: got %b want 1", bus.cmd_rdy); end
    next();
    bus.clr_cmd_rdy = 1'b1;
    next();
    bus.clr_cmd_rdy = 1'b0; move = 8'h80; start_tour = 1'b1;
    settle();
    n_checks++; if (bus.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL waitv_rdy: got %b want 0", bus.cmd_rdy); end
    next();
    start_tour = 1'b0;
    settle();
    n_checks++; if (bus.cmd_rdy !== 1'b0 || mv_indx !== '0) begin n_fail++; $display("FAIL restart_ignored: rdy %b idx %0d want 0/0", bus.cmd_rdy, mv_indx); end
    next();
    bus.send_resp = 1'b1;
    next();
    bus.send_resp = 1'b0;
    settle();
    n_checks++; if (bus.cmd !== 16'h3BF1) begin n_fail++; $display("FAIL horz_cmd: got %h want 3bf1", bus.cmd); end
    n_checks++; if (bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL horz_rdy: got %b want 1", bus.cmd_rdy); end
    n_checks++; if (bus.resp !== 8'hA5) begin n_fail++; $display("FAIL horz_resp: got %h want a5", bus.resp); end
    do_reset();
  endtask

  task automatic test_simultaneous();
    move = 8'h08; start_tour = 1'b1;
    next();
    start_tour = 1'b0;
    settle();
    n_checks++; if (bus.cmd !== 16'h27F1 || bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL bit3_vert: got %h/%b want 27f1/1", bus.cmd, bus.cmd_rdy); end
    next();
    bus.clr_cmd_rdy = 1'b1; bus.send_resp = 1'b1;
    next();
    bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
    settle();
    n_checks++; if (bus.cmd !== 16'h33F2 || bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL bit3_horz_direct: got %h/%b want 33f2/1", bus.cmd, bus.cmd_rdy); end
    do_reset();
  endtask

  task automatic test_illegal();
    logic [7:0] pats[3];
    int errs;
    int b0, b1;
    b0 = $urandom_range(0, 3); b1 = $urandom_range(4, 7);
    pats[0] = 8'h03; pats[1] = 8'h00; pats[2] = (8'h01 << b0) | (8'h01 << b1);
    for (int p = 0; p < 3; p++) begin
      errs = 0;
      move = pats[p]; start_tour = 1'b1;
      next();
      start_tour = 1'b0;
      settle();
      errs += int'(tour_err);
      n_checks++; if (bus.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL illegal_rdy: move %h got %b want 0", pats[p], bus.cmd_rdy); end
      next();
      settle();
      errs += int'(tour_err);
      n_checks++; if (tour_busy !== 1'b0 || mv_indx !== '0) begin n_fail++; $display("FAIL illegal_idle: move %h busy %b idx %0d want 0/0", pats[p], tour_busy, mv_indx); end
      next();
      settle();
      errs += int'(tour_err);
      n_checks++; if (errs !== 1) begin n_fail++; $display("FAIL illegal_err_pulse: move %h got %0d pulses want 1", pats[p], errs); end
      next();
    end
  endtask

  task automatic test_full_tour();
    logic [7:0]  tm[NUM_MOVES];
    logic [15:0] ucmd;
    logic [7:0]  exp_resp;
    int gap;
    bit sim_v, sim_h;
    for (int k = 0; k < NUM_MOVES; k++) tm[k] = 8'h01 << $urandom_range(0, 7);
    ucmd = 16'($urandom);
    n_cmds = 0; cnt_en = 1'b1;
    bus.cmd_UART = ucmd; bus.cmd_rdy_UART = 1'b1;
    start_tour = 1'b1;
    next();
    start_tour = 1'b0;
    for (int i = 0; i < NUM_MOVES; i++) begin
      move = tm[i];
      settle();
      n_checks++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== leg_cmd(tm[i], 1'b0)) begin n_fail++; $display("FAIL tour_vert: idx %0d got %h/%b want %h/1", i, bus.cmd, bus.cmd_rdy, leg_cmd(tm[i], 1'b0)); end
      n_checks++; if (mv_indx !== IDX_W'(i)) begin n_fail++; $display("FAIL tour_idx: got %0d want %0d", mv_indx, i); end
      n_checks++; if (bus.clr_cmd_rdy_UART !== 1'b0 || bus.resp !== 8'hA5) begin n_fail++; $display("FAIL tour_uart_blocked: idx %0d clr %b resp %h want 0/a5", i, bus.clr_cmd_rdy_UART, bus.resp); end
      gap = $urandom_range(0, 2);
      sim_v = ($urandom_range(0, 3) == 0);
      sim_h = (i != NUM_MOVES - 1) && ($urandom_range(0, 3) == 0);
      next();
      repeat (gap) next();
      bus.clr_cmd_rdy = 1'b1; bus.send_resp = sim_v;
      next();
      bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
      if (!sim_v) begin
        settle();
        n_checks++; if (bus.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL tour_waitv_rdy: idx %0d got %b want 0", i, bus.cmd_rdy); end
        next();
        repeat (gap) next();
        bus.send_resp = 1'b1;
        next();
        bus.send_resp = 1'b0;
      end
      settle();
      n_checks++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== leg_cmd(tm[i], 1'b1)) begin n_fail++; $display("FAIL tour_horz: idx %0d got %h/%b want %h/1", i, bus.cmd, bus.cmd_rdy, leg_cmd(tm[i], 1'b1)); end
      next();
      repeat (gap) next();
      bus.clr_cmd_rdy = 1'b1; bus.send_resp = sim_h;
      next();
      bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b0;
      if (!sim_h) begin
        settle();
        exp_resp = (i == NUM_MOVES - 1) ? 8'h5A : 8'hA5;
        n_checks++; if (bus.cmd_rdy !== 1'b0 || bus.resp !== exp_resp) begin n_fail++; $display("FAIL tour_waith: idx %0d rdy %b resp %h want 0/%h", i, bus.cmd_rdy, bus.resp, exp_resp); end
        next();
        bus.send_resp = 1'b1;
        next();
        bus.send_resp = 1'b0;
      end
    end
    bus.cmd_rdy_UART = 1'b0;
    settle();
    cnt_en = 1'b0;
    n_checks++; if (tour_busy !== 1'b0) begin n_fail++; $display("FAIL tour_done_busy: got %b want 0", tour_busy); end
    n_checks++; if (n_cmds !== 2 * NUM_MOVES) begin n_fail++; $display("FAIL tour_cmd_count: got %0d want %0d", n_cmds, 2 * NUM_MOVES); end
    next();
  endtask

  task automatic test_reset_mid_tour();
    move = 8'h01; start_tour = 1'b1;
    next();
    start_tour = 1'b0; bus.clr_cmd_rdy = 1'b1;
    next();
    bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b1;
    next();
    bus.send_resp = 1'b0; bus.clr_cmd_rdy = 1'b1;
    next();
    bus.clr_cmd_rdy = 1'b0; bus.send_resp = 1'b1;
    next();
    bus.send_resp = 1'b0; move = 8'h02; bus.clr_cmd_rdy = 1'b1;
    next();
    bus.clr_cmd_rdy = 1'b0; bus.cmd_UART = 16'h1234; bus.cmd_rdy_UART = 1'b1;
    settle();
    n_checks++; if (mv_indx !== IDX_W'(1) || tour_busy !== 1'b1 || bus.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_waitv: idx %0d busy %b rdy %b want 1/1/0", mv_indx, tour_busy, bus.cmd_rdy); end
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    settle();
    n_checks++; if (tour_busy !== 1'b0 || mv_indx !== '0) begin n_fail++; $display("FAIL mid_reset: busy %b idx %0d want 0/0", tour_busy, mv_indx); end
    n_checks++; if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h1234) begin n_fail++; $display("FAIL mid_reset_pass: got %h/%b want 1234/1", bus.cmd, bus.cmd_rdy); end
    do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    test_reset();
    test_passthrough();
    test_single_move();
    test_simultaneous();
    test_illegal();
    test_full_tour();
    test_full_tour();
    test_reset_mid_tour();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tour_move_sequencer.md
Name: tour_move_sequencer

Overview:
- Sequences a solved Knight's tour into `cmd_proc` movement commands.
- Arbitrates the single `cmd_proc` command port between the UART command path and the tour path.
- Sits between `UART_wrapper`/`TourLogic` and `cmd_proc` in `KnightsTour`.
- Each L-shaped move becomes two commands: the vertical leg first, then the horizontal leg. The response byte returned to the remote is set here.

Parameters:
- NUM_MOVES, 24, number of tour moves to sequence (5x5 board); last index is NUM_MOVES-1.
- IDX_W, 5, width of the move index.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start_tour  in  1  pulse from `cmd_proc`: solution ready, begin sequencing
- move  in  8  one-hot move for the current `mv_indx` (from `TourLogic`)
- mv_indx  out  IDX_W  index of the move being executed
- cmd_UART  in  16  command from `UART_wrapper`
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  consume strobe back to `UART_wrapper`
- cmd  out  16  command to `cmd_proc`
- cmd_rdy  out  1  command valid to `cmd_proc`
- clr_cmd_rdy  in  1  `cmd_proc` consumed `cmd`
- send_resp  in  1  `cmd_proc` finished the current command
- resp  out  8  response byte for the remote
- tour_busy  out  1  high whenever not IDLE
- tour_err  out  1  one-cycle pulse on an illegal move encoding

Behaviour:
- Reset (synchronous, rst=1):
  - state=IDLE, mv_indx=0, tour_err=0.
  - Outputs then follow the IDLE mux; cmd_rdy=0 when cmd_rdy_UART=0.
- Command format: cmd = {opcode[3:0], heading[7:0], squares[3:0]}.
  - Vertical leg: opcode 4'h2 (move).
  - Horizontal leg: opcode 4'h3 (move with fanfare).
  - Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Move decode (bit: dx,dy):
  - bit0: +1,+2; bit1: -1,+2; bit2: -2,+1; bit3: -2,-1
  - bit4: -1,-2; bit5: +1,-2; bit6: +2,-1; bit7: +2,+1
  - Vertical leg uses |dy| squares: N if dy>0, else S.
  - Horizontal leg uses |dx| squares: E if dx>0, else W.
- Move register: `move` is sampled into a move register on entry to VERT. The register is held through both legs.
- IDLE (UART pass-through):
  - cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'h5A.
  - start_tour=1 → VERT next cycle, mv_indx=0.
- Tour mode (any non-IDLE state):
  - cmd_rdy_UART is ignored; clr_cmd_rdy_UART=0, so a pending UART command waits.
  - resp=8'hA5, except in WAIT_H when mv_indx==NUM_MOVES-1, where resp=8'h5A.
- VERT:
  - cmd=vertical leg, cmd_rdy=1, held until clr_cmd_rdy.
  - clr_cmd_rdy → WAIT_V.
  - clr_cmd_rdy and send_resp in the same cycle → HORZ.
  - Illegal move (not exactly one bit set) → tour_err pulse, IDLE, mv_indx=0, and no cmd_rdy issued in that cycle. Decode is combinational on entry.
- WAIT_V: cmd_rdy=0; send_resp → HORZ.
- HORZ:
  - cmd=horizontal leg, cmd_rdy=1 until clr_cmd_rdy, then → WAIT_H.
  - Simultaneous clr_cmd_rdy and send_resp are handled as in VERT.
- WAIT_H: on send_resp:
  - If mv_indx==NUM_MOVES-1 → IDLE (tour done).
  - Else mv_indx+1 → VERT.
- Ignored inputs:
  - send_resp in VERT/HORZ without clr_cmd_rdy.
  - start_tour while tour_busy.
- Latency: start_tour to first cmd_rdy = 1 cycle. send_resp in WAIT_x to next cmd_rdy = 1 cycle.
- Width rule: mv_indx never increments past NUM_MOVES-1, so there is no wrap.
- Reset mid-tour: immediate IDLE, mv_indx=0, cmd_rdy reverts to pass-through.

Test Plan:
- IDLE pass-through: cmd_UART=16'h6020, cmd_rdy_UART=1, pulse clr_cmd_rdy → cmd=16'h6020, clr_cmd_rdy_UART pulses, resp=8'h5A, tour_busy=0.
- Single move bit0: start_tour, move=8'h01.
  - First: cmd=16'h2002, cmd_rdy=1 one cycle later, until clr_cmd_rdy.
  - After send_resp: cmd=16'h3BF1, resp=8'hA5.
- Move bit3 (move=8'h08) → cmd=16'h27F1, then cmd=16'h33F2.
- Full tour with NUM_MOVES=24, any legal moves:
  - mv_indx runs 0..23; exactly 48 cmd_rdy assertions.
  - resp=8'h5A only in WAIT_H at index 23; then IDLE, tour_busy=0.
- Illegal move=8'h03 at index 0 → tour_err pulses once, state IDLE, no cmd_rdy issued.
- Edge cases:
  - UART cmd_rdy_UART=1 during a tour → clr_cmd_rdy_UART stays 0, UART command not forwarded.
  - rst=1 mid-WAIT_V → next cycle tour_busy=0, mv_indx=0.
  - Simultaneous clr_cmd_rdy+send_resp in VERT → HORZ directly.
